// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types and constants
package mips_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DROP, HOLD} fetch_state_e;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: redirect priority, word-aligned redirect target and sequential pc+4
module if_next_pc import mips_pkg::*; (
  input  logic [31:0] pc_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic [31:0] pc_plus4_o
);
  assign redirect_o = branch_taken_i | jump_i;
  assign target_o = align_word(branch_taken_i ? branch_target_i : jump_target_i);
  assign pc_plus4_o = pc_i + PC_STEP;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC and issues single-outstanding fetches to a variable-latency imem,
// presenting registered instruction/pcPlus4/fetchValid to the IF/ID register.
module if_fetch_stage import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  output logic [31:0] pcPlus4,
  output logic        fetchValid
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, instr_q, instr_d, pcp4_q, pcp4_d, buf_q, buf_d;
  logic [31:0] target, pc_plus4, word;
  logic req_q, req_d, valid_q, valid_d, redirect, issue, deliver;

  if_next_pc u_next_pc (
    .pc_i           (pc_q),
    .branch_taken_i (branchTaken),
    .branch_target_i(branchTarget),
    .jump_i         (jump),
    .jump_target_i  (jumpTarget),
    .redirect_o     (redirect),
    .target_o       (target),
    .pc_plus4_o     (pc_plus4)
  );

  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    issue = 1'b0;
    deliver = 1'b0;
    word = imemData;
    case (state_q)
      IDLE: begin
        issue = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (imemValid && redirect) issue = 1'b1;
        else if (imemValid && stall) begin
          buf_d = imemData;
          state_d = HOLD;
        end else if (imemValid) begin
          deliver = 1'b1;
          issue = 1'b1;
        end else if (redirect) state_d = DROP;
      end
      HOLD: begin
        if (redirect) begin
          issue = 1'b1;
          state_d = WAIT;
        end else if (!stall) begin
          deliver = 1'b1;
          word = buf_q;
          issue = 1'b1;
          state_d = WAIT;
        end
      end
      DROP: begin
        if (imemValid) begin
          issue = 1'b1;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    // every request goes to the pc being installed this edge
    pc_d = redirect ? target : deliver ? pc_plus4 : pc_q;
    req_d = issue;
    addr_d = issue ? pc_d : addr_q;
    instr_d = deliver ? word : (stall && !redirect) ? instr_q : NOP_INSTR;
    pcp4_d = deliver ? pc_plus4 : pcp4_q;
    valid_d = deliver | (stall & ~redirect & valid_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      req_q <= 1'b0;
      addr_q <= '0;
      instr_q <= NOP_INSTR;
      pcp4_q <= '0;
      valid_q <= 1'b0;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_q <= req_d;
      addr_q <= addr_d;
      instr_q <= instr_d;
      pcp4_q <= pcp4_d;
      valid_q <= valid_d;
      buf_q <= buf_d;
    end
  end

  assign imemReq = req_q;
  assign imemAddr = addr_q;
  assign instruction = instr_q;
  assign pcPlus4 = pcp4_q;
  assign fetchValid = valid_q;

  // a response with nothing outstanding is a memory protocol violation
  assert property (@(posedge clock) disable iff (reset) imemValid |-> (state_q == WAIT || state_q == DROP));
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed plan steps then random stimulus, checked every cycle against a flag-based fetch model.
module tb_if_fetch_stage;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;
  logic clock = 1'b0;
  logic reset, stall, branchTaken, jump, imemValid, imemValid_w;
  logic [31:0] branchTarget, jumpTarget, imemData, imemData_w;
  logic imemReq, fetchValid, imemReq_w, fetchValid_w;
  logic [31:0] imemAddr, instruction, pcPlus4, imemAddr_w, instruction_w, pcPlus4_w;
  logic zero = 1'b0;
  logic [31:0] zero32 = '0;
  int tests = 0, fails = 0;
  int cnt = 0, cnt_w = 0, lat = 1;
  logic [31:0] maddr = '0, maddr_w = '0;
  logic [31:0] m_pc, m_addr, m_ins, m_p4, m_buf, m_out;
  logic m_req, m_fv, pend, stale, held, fresh;

  always #5 clock = ~clock;

  if_fetch_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget), .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid),
    .imemData(imemData), .instruction(instruction), .pcPlus4(pcPlus4), .fetchValid(fetchValid)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clock(clock), .reset(reset), .stall(zero), .branchTaken(zero), .branchTarget(zero32),
    .jump(zero), .jumpTarget(zero32), .imemReq(imemReq_w), .imemAddr(imemAddr_w), .imemValid(imemValid_w),
    .imemData(imemData_w), .instruction(instruction_w), .pcPlus4(pcPlus4_w), .fetchValid(fetchValid_w)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2008_0005 : ((a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    logic v, red, issue, dlv;
    logic [31:0] tgt, w;
    reset = r; stall = s; branchTaken = b; branchTarget = bt; jump = j; jumpTarget = jt;
    v = (cnt == 1);
    imemValid = v;
    imemData = v ? mem(maddr) : $urandom;
    if (cnt > 0) cnt--;
    imemValid_w = (cnt_w == 1);
    imemData_w = mem(maddr_w);
    if (cnt_w > 0) cnt_w--;
    @(posedge clock);
    if (r) begin
      m_pc = RPC; m_req = 0; m_addr = 0; m_ins = NOP; m_p4 = 0; m_fv = 0;
      pend = 0; stale = 0; held = 0; fresh = 1;
    end else begin
      red = b | j;
      tgt = b ? {bt[31:2], 2'b00} : {jt[31:2], 2'b00};
      issue = 0; dlv = 0; w = NOP;
      if (fresh) begin fresh = 0; issue = 1; end
      else if (pend && v) begin
        pend = 0;
        if (red) issue = 1;
        else if (s) begin held = 1; m_buf = mem(m_out); end
        else begin dlv = 1; w = mem(m_out); issue = 1; end
      end
      else if (pend && red) begin pend = 0; stale = 1; end
      else if (held && red) begin held = 0; issue = 1; end
      else if (held && !s) begin held = 0; dlv = 1; w = m_buf; issue = 1; end
      else if (stale && v) begin stale = 0; issue = 1; end
      if (dlv) m_p4 = m_pc + 32'd4;
      m_pc = red ? tgt : dlv ? m_pc + 32'd4 : m_pc;
      m_ins = dlv ? w : (s && !red) ? m_ins : NOP;
      m_fv = dlv | (s & !red & m_fv);
      m_req = issue;
      if (issue) begin m_addr = m_pc; m_out = m_pc; pend = 1; end
    end
    #1;
    if (imemReq) begin cnt = lat + 1; maddr = imemAddr; end
    if (imemReq_w) begin cnt_w = 2; maddr_w = imemAddr_w; end
    chk("imemReq", imemReq, m_req);
    if (m_req) chk("imemAddr", imemAddr, m_addr);
    chk("instruction", instruction, m_ins);
    chk("pcPlus4", pcPlus4, m_p4);
    chk("fetchValid", fetchValid, m_fv);
  endtask

  task automatic nop_step(input logic s);
    step(1'b0, s, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset fetchValid", fetchValid, 0);
    chk("reset instruction", instruction, NOP);
    nop_step(0);
    chk("t1 req", imemReq, 1);
    chk("t1 addr", imemAddr, 32'h0);
    repeat (2) nop_step(0);
    chk("t1 instruction", instruction, 32'h2008_0005);
    chk("t1 pcPlus4", pcPlus4, 32'h4);
    chk("t1 fetchValid", fetchValid, 1);
    chk("t1 next addr", imemAddr, 32'h4);
    chk("t5 pcPlus4 wrap", pcPlus4_w, 32'h0);
    chk("t5 instruction", instruction_w, mem(32'hFFFF_FFFC));
    chk("t5 fetchValid", fetchValid_w, 1);
    chk("t5 next req", imemReq_w, 1);
    chk("t5 next addr", imemAddr_w, 32'h0);
    repeat (3) nop_step(1);
    chk("t2 held instruction", instruction, 32'h2008_0005);
    chk("t2 held valid", fetchValid, 1);
    chk("t2 no req", imemReq, 0);
    nop_step(0);
    chk("t2 buffered word", instruction, mem(32'h4));
    chk("t2 pcPlus4", pcPlus4, 32'h8);
    chk("t2 next addr", imemAddr, 32'h8);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0);
    chk("t3 bubble", fetchValid, 0);
    nop_step(0);
    chk("t3 req", imemReq, 1);
    chk("t3 addr", imemAddr, 32'h0000_0100);
    nop_step(0);
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
    chk("t4 addr", imemAddr, 32'h40);
    chk("t4 bubble", fetchValid, 0);
    repeat (2) nop_step(0);
    chk("t4 delivered", instruction, mem(32'h40));
    lat = 3;
    repeat (2) nop_step(0);
    chk("t6 pre-reset pcPlus4", pcPlus4, 32'h48);
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    nop_step(0);
    chk("t6 new req addr", imemAddr, RPC);
    repeat (3) nop_step(0);
    chk("t6 stale ignored", fetchValid, 0);
    chk("t6 stale ins", instruction, NOP);
    nop_step(0);
    chk("t6 instruction", instruction, 32'h2008_0005);
    chk("t6 pcPlus4", pcPlus4, 32'h4);
    for (int i = 0; i < 1500; i++) begin
      lat = $urandom_range(1, 3);
      if ($urandom_range(0, 99) == 0) repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      else step(1'b0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom,
                $urandom_range(0, 7) == 0, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
